hls_deadlock_multi_monitor: RTL

HLS_DEADLOCK_MULTI_MONITOR -- requirements
Module: hls_deadlock_multi_monitor

---
 rtl/hls_deadlock_multi_monitor.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hls_deadlock_multi_monitor.sv
// hls_deadlock_multi_monitor
//   Flags a dataflow deadlock in an HLS design. It asserts when at least one
//   AXI-Stream channel is stalled and every monitored process is idle, blocked
//   on a FIFO/channel, or owns a stalled AXIS channel. This must hold for
//   HOLD_CYCLES consecutive cycles.
//
//   Optional feature: define DEADLOCK_MON_STICKY_EN to make the flag sticky.
//   Once set, block stays high until clear or reset. axis_block_info then keeps
//   the channel snapshot taken when BLOCKED was entered. With the macro
//   undefined, block follows the deadlock condition and axis_block_info
//   tracks the live stalls while blocked.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   axis_block_sigs     : [NUM_AXIS] per-channel AXIS stall
//   inst_idle_sigs      : [NUM_PROC] per-process idle
//   inst_block_sigs     : [NUM_PROC] per-process FIFO/channel block
//   clear               : 1-cycle pulse, clears flag, info and event counter
//   block               : registered deadlock flag
//   axis_block_info     : [NUM_AXIS] stalled channels, zero while block=0
//   event_count         : [CNT_W] saturating count of entries into BLOCKED

// Per-process qualifier: gathers the AXIS stalls owned by one process.
module hls_deadlock_proc_qual #(
    parameter int                    NUM_AXIS = 1,
    parameter logic [NUM_AXIS*5-1:0] AXIS_MAP = '0,
    parameter int                    PROC_IDX = 0
) (
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                inst_idle,
    input  logic                inst_block,
    output logic                proc_axis,
    output logic                proc_ok
);
    always_comb begin
        proc_axis = 1'b0;
        for (int i = 0; i < NUM_AXIS; i++) begin
            if (AXIS_MAP[5*i +: 5] == 5'(PROC_IDX))
                proc_axis = proc_axis | axis_block_sigs[i];
        end
        proc_ok = inst_idle | inst_block | proc_axis;
    end
endmodule

module hls_deadlock_multi_monitor #(
    parameter int                    NUM_PROC    = 3,
    parameter int                    NUM_AXIS    = 1,
    parameter logic [NUM_AXIS*5-1:0] AXIS_MAP    = '0,
    parameter int                    HOLD_CYCLES = 1,
    parameter int                    CNT_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic [NUM_AXIS-1:0] axis_block_info,
    output logic [CNT_W-1:0]    event_count
);
    localparam int ARM_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMING, S_BLOCKED} state_t;

    state_t             state;
    logic [ARM_W-1:0]   cnt;
    logic [NUM_PROC-1:0] proc_axis;
    logic [NUM_PROC-1:0] proc_ok;
    logic               cond;

    for (genvar p = 0; p < NUM_PROC; p++) begin : g_proc
        hls_deadlock_proc_qual #(
            .NUM_AXIS (NUM_AXIS),
            .AXIS_MAP (AXIS_MAP),
            .PROC_IDX (p)
        ) u_qual (
            .axis_block_sigs (axis_block_sigs),
            .inst_idle       (inst_idle_sigs[p]),
            .inst_block      (inst_block_sigs[p]),
            .proc_axis       (proc_axis[p]),
            .proc_ok         (proc_ok[p])
        );
    end

    // A deadlock needs at least one real AXIS stall. All-idle alone is not one.
    assign cond = (|proc_axis) & (&proc_ok);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            // Reset and clear share the same effect. Both override any
            // transition or count increment on this edge.
            state           <= S_IDLE;
            cnt             <= '0;
            block           <= 1'b0;
            axis_block_info <= '0;
            event_count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (cond) begin
                        if (HOLD_CYCLES == 1) begin
                            state           <= S_BLOCKED;
                            block           <= 1'b1;
                            axis_block_info <= axis_block_sigs;
                            if (event_count != '1)
                                event_count <= event_count + CNT_W'(1);
                        end else begin
                            state <= S_ARMING;
                            cnt   <= ARM_W'(1);
                        end
                    end
                end
                S_ARMING: begin
                    if (!cond) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == ARM_W'(HOLD_CYCLES - 1)) begin
                        state           <= S_BLOCKED;
                        cnt             <= '0;
                        block           <= 1'b1;
                        axis_block_info <= axis_block_sigs;
                        if (event_count != '1)
                            event_count <= event_count + CNT_W'(1);
                    end else begin
                        cnt <= cnt + ARM_W'(1);
                    end
                end
                S_BLOCKED: begin
`ifdef DEADLOCK_MON_STICKY_EN
                    // Hold flag and entry snapshot until clear/reset.
                    block <= 1'b1;
`else
                    if (cond) begin
                        axis_block_info <= axis_block_sigs;
                    end else begin
                        state           <= S_IDLE;
                        block           <= 1'b0;
                        axis_block_info <= '0;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    block <= 1'b0;
                end
            endcase
        end
    end
endmodule
